// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter/sequencer for a shared single-port synchronous RAM.
// Define ARB_FIXED_PRIO_EN to make requester 0 win every tie instead of alternating.
module ram_arbiter #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] adr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] adr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] ram_adr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_dout
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

    state_t state;
    logic   grant;
    logic   grant_we;
    logic   elig0;
    logic   elig1;
    logic   pick;

    // A requester whose ack is still high has not yet had the chance to drop req.
    assign elig0 = req0 & ~ack0;
    assign elig1 = req1 & ~ack1;

`ifdef ARB_FIXED_PRIO_EN
    assign pick = ~elig0;
`else
    logic last_grant;
    assign pick = (elig0 & elig1) ? ~last_grant : elig1;
`endif

    // NOTE: all state lives in one clocked block with non-blocking assignments,
    // so every branch sees the pre-edge values of ack, state and last_grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= 1'b0;
            grant_we <= 1'b0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            rdata0   <= '0;
            rdata1   <= '0;
            ram_adr  <= '0;
            ram_din  <= '0;
            ram_we   <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
            last_grant <= 1'b1;
`endif
        end else begin
            // NOTE: acks default low every edge, which makes each one a single-cycle pulse.
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (elig0 | elig1) begin
                        grant    <= pick;
                        grant_we <= pick ? we1 : we0;
                        ram_we   <= pick ? we1 : we0;
                        ram_adr  <= pick ? adr1 : adr0;
                        ram_din  <= pick ? wdata1 : wdata0;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    ram_we <= 1'b0;
                    state  <= CAPTURE;
                end
                CAPTURE: begin
                    if (grant) begin
                        if (!grant_we) rdata1 <= ram_dout;
                        ack1 <= 1'b1;
                    end else begin
                        if (!grant_we) rdata0 <= ram_dout;
                        ack0 <= 1'b1;
                    end
`ifndef ARB_FIXED_PRIO_EN
                    last_grant <= grant;
`endif
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
